// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: jump/flush/hold sequencing and drain-then-grant bus arbitration for the 3-stage core.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int RUN_MIN      = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              mdu_busy,
    input  logic              bus_req,
    output logic              bus_gnt,
    output logic              pc_jump,
    output logic [ADDR_W-1:0] pc_jump_addr,
    output logic              pc_hold,
    output logic              if_id_flush,
    output logic              if_id_hold,
    output logic              id_ex_flush,
    output logic              id_ex_hold
);
    localparam int DW = $clog2(DRAIN_CYCLES);
    localparam int FW = $clog2(RUN_MIN + 1);

    typedef enum logic [1:0] {RUN, DRAIN, GRANT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [FW-1:0] fair_cnt_q, fair_cnt_d;
    logic          bus_gnt_q, bus_gnt_d;

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        fair_cnt_d   = fair_cnt_q;
        pc_jump      = 1'b0;
        pc_jump_addr = '0;
        pc_hold      = 1'b0;
        if_id_flush  = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        if (!sys_rst) begin
            case (state_q)
                RUN: begin
                    fair_cnt_d = (fair_cnt_q != '0) ? fair_cnt_q - FW'(1) : '0;
                    if (jump_req) begin
                        pc_jump      = 1'b1;
                        pc_jump_addr = jump_addr;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (mdu_busy) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end else if (bus_req && fair_cnt_q == '0) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    // PC stays parked on the flushed fetch so it is refetched after the grant
                    pc_hold = 1'b1;
                    if (jump_req) begin
                        pc_jump      = 1'b1;
                        pc_jump_addr = jump_addr;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (mdu_busy) begin
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                    end
                    if ((jump_req || !mdu_busy) && drain_cnt_q != '0)
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    if (drain_cnt_q == '0 && !mdu_busy)
                        state_d = GRANT;
                end
                GRANT: begin
                    pc_hold     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!bus_req) begin
                        state_d    = RUN;
                        fair_cnt_d = FW'(RUN_MIN);
                    end
                end
                default: state_d = RUN;
            endcase
        end
        bus_gnt_d = (state_d == GRANT);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            fair_cnt_q  <= '0;
            bus_gnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fair_cnt_q  <= fair_cnt_d;
            bus_gnt_q   <= bus_gnt_d;
        end
    end

    assign bus_gnt = bus_gnt_q;
endmodule
